// File: rtl/rainbow_pwm_pkg.sv
// Purpose: shared constants and small helpers for the rainbow PWM LED driver.
// Latency: n/a (definitions only).
// Backpressure: n/a.
//   Contents: segment codes of the colour wheel, LED pin bit indices,
//   and segment increment/decrement/clamp helpers.
package rainbow_pwm_pkg;

    localparam int N_SEG = 6;

    // Colour wheel segments, walked R>Y>G>C>B>M>R in the forward direction
    localparam logic [2:0] SEG_R = 3'd0;
    localparam logic [2:0] SEG_Y = 3'd1;
    localparam logic [2:0] SEG_G = 3'd2;
    localparam logic [2:0] SEG_C = 3'd3;
    localparam logic [2:0] SEG_B = 3'd4;
    localparam logic [2:0] SEG_M = 3'd5;

    // Pin order on the board is {R, B, G}
    localparam int LED_R = 2;
    localparam int LED_B = 1;
    localparam int LED_G = 0;

    function automatic logic [2:0] seg_inc(input logic [2:0] s);
        return (s == SEG_M) ? SEG_R : s + 3'd1;
    endfunction

    function automatic logic [2:0] seg_dec(input logic [2:0] s);
        return (s == SEG_R) ? SEG_M : s - 3'd1;
    endfunction

    // Codes 6 and 7 do not exist on the wheel; they fold back to red
    function automatic logic [2:0] seg_clamp(input logic [2:0] s);
        return (s >= 3'(N_SEG)) ? SEG_R : s;
    endfunction

endpackage

// File: rtl/rainbow_pwm_chan.sv
// Purpose: one colour channel: brightness scaling, frame-aligned duty latch, PWM compare.
// Latency: duty change visible from the next PWM frame; o_lit is combinational on i_pwm_cnt.
// Backpressure: none (free-running).
//   Ports: i_clk, i_rst (async, active high), i_level (colour level), i_bright
//   (global brightness), i_pwm_cnt (shared frame counter), o_lit (channel on).
module rainbow_pwm_chan #(
    parameter int PWM_BITS = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [PWM_BITS-1:0] i_level,
    input  logic [PWM_BITS-1:0] i_bright,
    input  logic [PWM_BITS-1:0] i_pwm_cnt,
    output logic                o_lit
);

    localparam int PW2 = 2 * PWM_BITS + 1;

    logic [PW2-1:0]      w_bright1;
    logic [PW2-1:0]      w_prod;
    logic [PWM_BITS-1:0] w_duty;
    logic [PWM_BITS-1:0] r_duty;

    // (bright+1) makes full brightness an exact pass-through of the level
    // and zero brightness fully dark; the product can never exceed PW2 bits.
    assign w_bright1 = PW2'(i_bright) + PW2'(1);
    assign w_prod    = PW2'(i_level) * w_bright1;
    assign w_duty    = PWM_BITS'(w_prod >> PWM_BITS);

    // Latch only on the last count of a frame so a frame never mixes two duties
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_duty <= '0;
        end else if (i_pwm_cnt == '1) begin
            r_duty <= w_duty;
        end
    end

    assign o_lit = (i_pwm_cnt < r_duty);

endmodule

// File: rtl/rainbow_pwm.sv
// Purpose: rainbow driver for the RGB LED: hue accumulator over a 6-segment wheel with per-channel PWM.
// Latency: hue/brightness changes reach the pins within one PWM frame + 1 clk; o_led is registered.
// Backpressure: none; i_load is a single-cycle pulse that always wins over a step.
//   Ports: i_clk, i_rst (async, active high), i_en (advance hue), i_dir (0 fwd, 1 rev),
//   i_bright (global brightness), i_load/i_hue_in ({seg, frac} load), o_hue (current
//   {seg, frac}), o_wrap (pulse on 5<->0 segment change), o_led ({R, B, G} pins).
module rainbow_pwm
    import rainbow_pwm_pkg::*;
#(
    parameter int PWM_BITS   = 8,
    parameter int STEP_TICKS = 46875,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_dir,
    input  logic [PWM_BITS-1:0]   i_bright,
    input  logic                  i_load,
    input  logic [PWM_BITS+2:0]   i_hue_in,
    output logic [PWM_BITS+2:0]   o_hue,
    output logic                  o_wrap,
    output logic [2:0]            o_led
);

    localparam logic [PWM_BITS-1:0] MAX     = '1;
    localparam int                  PSW     = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam logic [2:0]          LED_OFF = (ACTIVE_LOW != 0) ? 3'b111 : 3'b000;

    logic [PSW-1:0]      r_presc;
    logic [2:0]          r_seg;
    logic [PWM_BITS-1:0] r_frac;
    logic                r_wrap;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [2:0]          r_led;

    logic                w_step;
    logic [PWM_BITS-1:0] w_up;
    logic [PWM_BITS-1:0] w_dn;
    logic [PWM_BITS-1:0] w_lvl_r;
    logic [PWM_BITS-1:0] w_lvl_g;
    logic [PWM_BITS-1:0] w_lvl_b;
    logic [2:0]          w_lit;

    assign w_step = i_en && (r_presc == PSW'(STEP_TICKS - 1));

    // Prescaler freezes while disabled; a load restarts the step period
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_presc <= '0;
        end else if (i_load) begin
            r_presc <= '0;
        end else if (i_en) begin
            r_presc <= w_step ? '0 : r_presc + PSW'(1);
        end
    end

    // Hue accumulator; wrap flags only a genuine step across the 5<->0 boundary
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_seg  <= SEG_R;
            r_frac <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (i_load) begin
                r_seg  <= seg_clamp(i_hue_in[PWM_BITS+2:PWM_BITS]);
                r_frac <= i_hue_in[PWM_BITS-1:0];
            end else if (w_step) begin
                if (!i_dir) begin
                    if (r_frac == MAX) begin
                        r_frac <= '0;
                        r_seg  <= seg_inc(r_seg);
                        r_wrap <= (r_seg == SEG_M);
                    end else begin
                        r_frac <= r_frac + PWM_BITS'(1);
                    end
                end else begin
                    if (r_frac == '0) begin
                        r_frac <= MAX;
                        r_seg  <= seg_dec(r_seg);
                        r_wrap <= (r_seg == SEG_R);
                    end else begin
                        r_frac <= r_frac - PWM_BITS'(1);
                    end
                end
            end
        end
    end

    // Colour map: inside each segment one channel ramps while the others hold
    assign w_up = r_frac;
    assign w_dn = MAX - r_frac;

    always_comb begin
        w_lvl_r = '0;
        w_lvl_g = '0;
        w_lvl_b = '0;
        case (r_seg)
            SEG_R: begin w_lvl_r = MAX;  w_lvl_g = w_up; end
            SEG_Y: begin w_lvl_r = w_dn; w_lvl_g = MAX;  end
            SEG_G: begin w_lvl_g = MAX;  w_lvl_b = w_up; end
            SEG_C: begin w_lvl_g = w_dn; w_lvl_b = MAX;  end
            SEG_B: begin w_lvl_r = w_up; w_lvl_b = MAX;  end
            SEG_M: begin w_lvl_r = MAX;  w_lvl_b = w_dn; end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
        end
    end

    rainbow_pwm_chan #(.PWM_BITS(PWM_BITS)) u_chan_r (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_level   (w_lvl_r),
        .i_bright  (i_bright),
        .i_pwm_cnt (r_pwm_cnt),
        .o_lit     (w_lit[LED_R])
    );

    rainbow_pwm_chan #(.PWM_BITS(PWM_BITS)) u_chan_g (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_level   (w_lvl_g),
        .i_bright  (i_bright),
        .i_pwm_cnt (r_pwm_cnt),
        .o_lit     (w_lit[LED_G])
    );

    rainbow_pwm_chan #(.PWM_BITS(PWM_BITS)) u_chan_b (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_level   (w_lvl_b),
        .i_bright  (i_bright),
        .i_pwm_cnt (r_pwm_cnt),
        .o_lit     (w_lit[LED_B])
    );

    // Registered pins with polarity folded in, so reset leaves the LED dark
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_led <= LED_OFF;
        end else begin
            r_led <= w_lit ^ LED_OFF;
        end
    end

    assign o_hue  = {r_seg, r_frac};
    assign o_wrap = r_wrap;
    assign o_led  = r_led;

endmodule

// File: tb/tb_rainbow_pwm.sv
module tb_rainbow_pwm;

    localparam int PW = 4;
    localparam int ST = 3;
    localparam int NH = 96;   // 6 segments x 16 hue steps

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       dir;
    logic [3:0] bright;
    logic       load;
    logic [6:0] hue_in;
    logic [6:0] hue;
    logic       wrap;
    logic [2:0] led;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: hue as a linear index 0..95 around the wheel
    int   m_h;
    int   m_ticks;
    logic m_wrap;

    rainbow_pwm #(.PWM_BITS(PW), .STEP_TICKS(ST), .ACTIVE_LOW(1)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_en     (en),
        .i_dir    (dir),
        .i_bright (bright),
        .i_load   (load),
        .i_hue_in (hue_in),
        .o_hue    (hue),
        .o_wrap   (wrap),
        .o_led    (led)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int level(input int h, input int ch);
        int s;
        int up;
        int dn;
        int c[3];
        s  = h / 16;
        up = h % 16;
        dn = 15 - up;
        c  = '{0, 0, 0};
        case (s)
            0: c = '{15, up, 0};
            1: c = '{dn, 15, 0};
            2: c = '{0, 15, up};
            3: c = '{0, dn, 15};
            4: c = '{up, 0, 15};
            5: c = '{15, 0, dn};
            default: c = '{0, 0, 0};
        endcase
        return c[ch];
    endfunction

    function automatic int exp_duty(input int h, input int ch, input int br);
        return (level(h, ch) * (br + 1)) / 16;
    endfunction

    // Advance the model by one clock using the currently driven inputs, then check the DUT
    task automatic cycle();
        if (load) begin
            m_h     = (int'(hue_in) / 16 >= 6) ? int'(hue_in) % 16 : int'(hue_in);
            m_ticks = 0;
            m_wrap  = 1'b0;
        end else if (en) begin
            m_ticks++;
            m_wrap = 1'b0;
            if (m_ticks == ST) begin
                m_ticks = 0;
                if (!dir) begin
                    m_wrap = (m_h == NH - 1);
                    m_h    = (m_h + 1) % NH;
                end else begin
                    m_wrap = (m_h == 0);
                    m_h    = (m_h + NH - 1) % NH;
                end
            end
        end else begin
            m_wrap = 1'b0;
        end
        @(posedge clk);
        #1;
        check("hue", 32'(hue), 32'(m_h));
        check("wrap", 32'(wrap), 32'(m_wrap));
    endtask

    // Count lit cycles per channel over one 16-cycle window (pins are active low)
    task automatic measure(input string tag, input int er, input int eg, input int eb);
        int cr;
        int cg;
        int cb;
        cr = 0;
        cg = 0;
        cb = 0;
        for (int k = 0; k < 16; k++) begin
            cycle();
            if (led[2] == 1'b0) cr++;
            if (led[0] == 1'b0) cg++;
            if (led[1] == 1'b0) cb++;
        end
        check({tag, "_R"}, 32'(cr), 32'(er));
        check({tag, "_G"}, 32'(cg), 32'(eg));
        check({tag, "_B"}, 32'(cb), 32'(eb));
    endtask

    task automatic model_reset();
        m_h     = 0;
        m_ticks = 0;
        m_wrap  = 1'b0;
    endtask

    initial begin
        int wraps;
        int rh;
        int rb;

        rst    = 1'b1;
        en     = 1'b0;
        dir    = 1'b0;
        bright = 4'd15;
        load   = 1'b0;
        hue_in = '0;
        model_reset();

        // Reset state
        #1;
        check("rst_led", 32'(led), 32'h7);
        check("rst_hue", 32'(hue), 0);
        check("rst_wrap", 32'(wrap), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();

        // Full forward revolution: 96 steps of 3 clocks each
        en     = 1'b1;
        dir    = 1'b0;
        bright = 4'd15;
        wraps  = 0;
        for (int k = 0; k < NH * ST; k++) begin
            cycle();
            if (wrap) wraps++;
        end
        check("rev_full_hue", 32'(hue), 0);
        check("rev_full_wraps", 32'(wraps), 1);
        en = 1'b0;

        // Single reverse step from hue 0 crosses 0->5
        dir = 1'b1;
        en  = 1'b1;
        repeat (ST) cycle();
        check("rev_step_hue", 32'(hue), 32'h5F);
        check("rev_step_wrap", 32'(wrap), 1);
        en = 1'b0;
        cycle();
        check("rev_wrap_clear", 32'(wrap), 0);
        dir = 1'b0;

        // Yellow: R and G full, B off
        hue_in = 7'h10;
        bright = 4'd15;
        load   = 1'b1;
        cycle();
        load = 1'b0;
        repeat (40) cycle();
        measure("yellow", 15, 15, 0);

        // Red at brightness 7: duty (15*8)>>4 = 7
        hue_in = 7'h00;
        bright = 4'd7;
        load   = 1'b1;
        cycle();
        load = 1'b0;
        repeat (40) cycle();
        measure("dim_red", 7, 0, 0);

        // Asynchronous reset mid-run, asserted between clock edges
        en = 1'b1;
        repeat (20) cycle();
        #2;
        rst = 1'b1;
        #1;
        check("arst_led", 32'(led), 32'h7);
        check("arst_hue", 32'(hue), 0);
        check("arst_wrap", 32'(wrap), 0);
        @(posedge clk);
        #1;
        check("arst_hold_hue", 32'(hue), 0);
        check("arst_hold_led", 32'(led), 32'h7);
        #3;
        rst = 1'b0;
        model_reset();

        // Load colliding with a step tick; out-of-range segment folds to 0
        en  = 1'b1;
        dir = 1'b0;
        for (int k = 0; k < 8 && m_ticks != ST - 1; k++) cycle();
        hue_in = 7'h73;
        load   = 1'b1;
        cycle();
        check("ld_step_hue", 32'(hue), 3);
        load = 1'b0;
        cycle();
        cycle();
        check("ld_presc_hold", 32'(hue), 3);
        cycle();
        check("ld_presc_step", 32'(hue), 4);

        // Randomised hue/wrap traffic against the model
        for (int k = 0; k < 600; k++) begin
            en     = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 49) == 0) dir = ~dir;
            load   = ($urandom_range(0, 29) == 0);
            hue_in = 7'($urandom_range(0, 127));
            bright = 4'($urandom_range(0, 15));
            cycle();
        end
        load = 1'b0;

        // Randomised colour/brightness points checked on the pins
        for (int k = 0; k < 4; k++) begin
            rh     = $urandom_range(0, 127);
            rb     = $urandom_range(0, 15);
            en     = 1'b0;
            hue_in = 7'(rh);
            bright = 4'(rb);
            load   = 1'b1;
            cycle();
            load = 1'b0;
            repeat (40) cycle();
            measure("rand_pwm", exp_duty(m_h, 0, rb), exp_duty(m_h, 1, rb), exp_duty(m_h, 2, rb));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
